biquad_sequencer: RTL and testbench
===================================

# biquad_sequencer

Sample and coefficient sequencer around one biquad EQ band. Accepts 16-bit PCM samples and gain commands over valid/ready handshakes, converts samples to the 32-bit Q15 format the biquad consumes, and drives the biquad's `set`/`next` control pins with legal timing. It waits for the biquad's combinational output to settle, then captures it, converts it back to saturated 16-bit PCM, and presents it downstream. Sits between the audio-codec receive path and the DAC transmit path.

## Interface
- `SETTLE`, default 2: cycles waited after the biquad latches a sample before `i_bq_data` is captured; legal range 1..15.
- `SET_WAIT`, default 4: cycles waited after an `o_bq_set` pulse before any further biquad traffic; legal range 3..15.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high; clock is `i_clk`.
- `i_pcm_valid`  in  1  upstream sample valid.
- `i_pcm`  in  16  signed PCM sample.
- `o_pcm_ready`  out  1  high when the sample FIFO is not full.
- `i_gain_valid`  in  1  gain command valid.
- `i_gain`  in  16  signed gain in dB (integer).
- `o_gain_ready`  out  1  high when no gain command is pending.
- `o_bq_set`  out  1  biquad coefficient-update pulse.
- `o_bq_gain`  out  16  gain presented to the biquad.
- `o_bq_next`  out  1  biquad sample strobe.
- `o_bq_data`  out  32  Q15 sample to the biquad.
- `i_bq_data`  in  32  Q15 filtered sample from the biquad.
- `o_out_valid`  out  1  output sample valid.
- `o_out_pcm`  out  16  saturated filtered PCM.
- `i_out_ready`  in  1  downstream ready.
- `o_busy`  out  1  high when the FSM is not in IDLE.

## Operation
- **Sample FIFO**
  - 2 entries.
  - Push when `i_pcm_valid && o_pcm_ready`.
  - Popped on the IDLE→NEXT_HI transition.
  - Push and pop in the same cycle are legal; a full FIFO deasserts ready, so no push occurs when full.
- **Gain register**
  - Loaded when `i_gain_valid && o_gain_ready`; this sets `pending`.
  - `pending` clears on entry to SET.
- **FSM states:** IDLE, SET, SET_WAIT, NEXT_HI, NEXT_LO, SETTLE, OUT.
- **IDLE**
  - If `pending`, go to SET. A gain command has priority over a queued sample.
  - Else if the FIFO is non-empty, pop and go to NEXT_HI.
- **SET**
  - `o_bq_set`=1 for exactly 1 cycle, with `o_bq_gain` = the gain register.
  - Go to SET_WAIT.
- **SET_WAIT**
  - Count `SET_WAIT` cycles with `o_bq_set`=0, then go to IDLE.
  - `o_bq_gain` holds its last value.
- **NEXT_HI**
  - `o_bq_data` = sign-extended sample << 15 (bits [14:0]=0, bits [31:31] copy the sign).
  - `o_bq_next`=1 for 1 cycle.
- **NEXT_LO**
  - `o_bq_next`=0 and `o_bq_data` held. The biquad latches the sample at the end of this cycle.
  - Go to SETTLE with the counter at 0.
- **SETTLE**
  - Count `SETTLE` cycles.
  - On the final edge, capture `o_out_pcm` = sat16(`i_bq_data` >>> 15), set `o_out_valid`=1, and go to OUT.
- **sat16**
  - Arithmetic shift, truncating toward −inf.
  - Values > 32767 → 0x7FFF; values < −32768 → 0x8000.
- **OUT**
  - Hold `o_out_valid` and `o_out_pcm` stable until `i_out_ready`=1.
  - On the handshake edge, clear valid and go to IDLE.
- `o_bq_data` holds its last value in every state outside NEXT_HI and NEXT_LO.

## Timing
- **Reset values**
  - All registered outputs are 0: `o_bq_set`, `o_bq_next`, `o_bq_data`, `o_bq_gain`, `o_out_valid`, `o_out_pcm`, `o_busy`.
  - FIFO empty, `pending`=0, FSM in IDLE.
  - Therefore `o_pcm_ready`=1 and `o_gain_ready`=1.
- **Latency**
  - Sample accepted at edge E0 into an empty FIFO, FSM in IDLE, no gain pending:
  - NEXT_HI from E1, NEXT_LO from E2, SETTLE from E3.
  - `o_out_valid` rises at edge E0+3+`SETTLE` (5 cycles by default).
- **Throughput:** one sample per 4+`SETTLE` cycles when `i_out_ready` stays 1.
- **Gain command while a sample is in flight:** stored as pending; applied only on the next IDLE; never interrupts NEXT_HI..OUT.
- **Gain arriving in the same cycle the FSM leaves IDLE for NEXT_HI:** the sample proceeds and SET follows after OUT.
- **Second gain while `pending`=1:** `o_gain_ready`=0, so the command stalls upstream.
- **Reset mid-operation:** asynchronous clear.
  - An in-flight sample, the FIFO contents and a pending gain are all discarded.
  - `o_bq_next` and `o_bq_set` drop immediately.

## Test plan
- **Passthrough:** loop `o_bq_data` to `i_bq_data`; push 0x1000.
  - `o_bq_data`=0x0800_0000 with a 1-cycle `o_bq_next`.
  - `o_out_pcm`=0x1000, with valid 5 cycles after acceptance.
- **Negative passthrough:** push 0xFFFF (−1).
  - `o_bq_data`=0xFFFF_8000 and `o_out_pcm`=0xFFFF.
  - Push 0x8000 → `o_out_pcm`=0x8000.
- **Saturation:** force `i_bq_data`=0x7FFF_FFFF → `o_out_pcm`=0x7FFF; force 0x8000_0000 → 0x8000.
- **Gain priority:** with the FSM busy, push sample A and gain 6.
  - After OUT, `o_bq_set` pulses for 1 cycle with `o_bq_gain`=0x0006.
  - Exactly 4 cycles follow with no `o_bq_next`, then A is issued.
- **Backpressure:** hold `i_out_ready`=0 and push 4 samples.
  - 3 are accepted (1 in flight + 2 in the FIFO) and `o_pcm_ready`=0 on the 4th.
  - `o_out_pcm` stays stable.
  - Release ready: outputs drain in order with no loss.
- **Reset mid-SETTLE:** assert `i_rst` during SETTLE.
  - All outputs go to 0 at once; `o_pcm_ready` and `o_gain_ready` are 1.
  - The next sample follows the nominal 5-cycle latency.

Source files
------------

// File: rtl/biquad_sequencer.sv
// Sequencer around one biquad EQ band: queues PCM samples and gain commands,
// drives the biquad set/next pins, and returns the settled result as saturated PCM.
module biquad_sequencer #(
    parameter int SETTLE   = 2,
    parameter int SET_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pcm_valid,
    input  logic signed [15:0] i_pcm,
    output logic               o_pcm_ready,
    input  logic               i_gain_valid,
    input  logic signed [15:0] i_gain,
    output logic               o_gain_ready,
    output logic               o_bq_set,
    output logic signed [15:0] o_bq_gain,
    output logic               o_bq_next,
    output logic signed [31:0] o_bq_data,
    input  logic signed [31:0] i_bq_data,
    output logic               o_out_valid,
    output logic signed [15:0] o_out_pcm,
    input  logic               i_out_ready,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_SET_WAIT, S_NEXT_HI, S_NEXT_LO, S_SETTLE, S_OUT
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic signed [15:0] fifo_mem [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         fifo_cnt;
    logic               push, pop, enter_set, capture, load_gain;
    logic               pending;
    logic signed [15:0] gain_reg;

    function automatic logic signed [31:0] to_q15(input logic signed [15:0] s);
        return {s[15], s, 15'b0};
    endfunction

    // Arithmetic shift floors toward -inf before clamping to the 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        logic signed [31:0] sh;
        sh = x >>> 15;
        if (sh > 32'sd32767)
            return 16'h7fff;
        else if (sh < -32'sd32768)
            return 16'h8000;
        return sh[15:0];
    endfunction

    assign o_pcm_ready  = (fifo_cnt != 2'd2);
    assign o_gain_ready = !pending;
    assign push         = i_pcm_valid && o_pcm_ready;
    assign load_gain    = i_gain_valid && o_gain_ready;

    assign o_bq_set  = (state == S_SET);
    assign o_bq_next = (state == S_NEXT_HI);
    assign o_busy    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        enter_set = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    state_nxt = S_SET;
                    enter_set = 1'b1;
                end else if (fifo_cnt != 2'd0) begin
                    state_nxt = S_NEXT_HI;
                    pop       = 1'b1;
                end
            end
            S_SET: begin
                state_nxt = S_SET_WAIT;
                cnt_nxt   = 4'd0;
            end
            // The IDLE cycle that follows is the last of the SET_WAIT quiet cycles.
            S_SET_WAIT: begin
                if (cnt == 4'(SET_WAIT - 2))
                    state_nxt = S_IDLE;
                else
                    cnt_nxt = cnt + 4'd1;
            end
            S_NEXT_HI: state_nxt = S_NEXT_LO;
            S_NEXT_LO: begin
                state_nxt = S_SETTLE;
                cnt_nxt   = 4'd0;
            end
            S_SETTLE: begin
                if (cnt == 4'(SETTLE - 1)) begin
                    state_nxt = S_OUT;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_OUT: begin
                if (i_out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            pending  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (load_gain)
                pending <= 1'b1;
            else if (enter_set)
                pending <= 1'b0;
        end
    end

    // Storage only; its validity is tracked by fifo_cnt and pending.
    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= i_pcm;
        if (load_gain)
            gain_reg <= i_gain;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bq_gain   <= '0;
            o_bq_data   <= '0;
            o_out_valid <= 1'b0;
            o_out_pcm   <= '0;
        end else begin
            if (enter_set)
                o_bq_gain <= gain_reg;
            if (pop)
                o_bq_data <= to_q15(fifo_mem[rd_ptr]);
            if (capture) begin
                o_out_valid <= 1'b1;
                o_out_pcm   <= sat16(i_bq_data);
            end else if (state == S_OUT && i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_biquad_sequencer.sv
// Directed and randomized bench for biquad_sequencer with a loopback or forced biquad
// result, compared against an arithmetic reference of the conversions and sequencing.
module tb_biquad_sequencer;
    localparam int SETTLE   = 2;
    localparam int SET_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcm_valid = 1'b0;
    logic [15:0] pcm_in = '0;
    logic        pcm_ready;
    logic        gain_valid = 1'b0;
    logic [15:0] gain_in = '0;
    logic        gain_ready;
    logic        bq_set;
    logic [15:0] bq_gain;
    logic        bq_next;
    logic [31:0] bq_data;
    logic [31:0] bq_in;
    logic        out_valid;
    logic [15:0] out_pcm;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        bq_force = 1'b0;
    logic [31:0] bq_force_val = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign bq_in = bq_force ? bq_force_val : bq_data;

    biquad_sequencer #(.SETTLE(SETTLE), .SET_WAIT(SET_WAIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pcm_valid(pcm_valid), .i_pcm(pcm_in), .o_pcm_ready(pcm_ready),
        .i_gain_valid(gain_valid), .i_gain(gain_in), .o_gain_ready(gain_ready),
        .o_bq_set(bq_set), .o_bq_gain(bq_gain), .o_bq_next(bq_next),
        .o_bq_data(bq_data), .i_bq_data(bq_in),
        .o_out_valid(out_valid), .o_out_pcm(out_pcm), .i_out_ready(out_ready),
        .o_busy(busy)
    );

    // Reference: Q15 value is the sample times 2^15.
    function automatic logic [31:0] exp_q15(input logic [15:0] s);
        longint v;
        v = longint'($signed(s)) * 32768;
        return v[31:0];
    endfunction

    // Reference: floor(v / 2^15), clamped to the signed 16-bit range.
    function automatic logic [15:0] ref_pcm(input logic [31:0] v);
        longint x, q;
        x = longint'($signed(v));
        if (x >= 0) q = x / 32768;
        else        q = -((-x + 32767) / 32768);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_set"},   32'(bq_set), 32'd0);
        check({tag, "_next"},  32'(bq_next), 32'd0);
        check({tag, "_data"},  bq_data, 32'd0);
        check({tag, "_gain"},  32'(bq_gain), 32'd0);
        check({tag, "_vld"},   32'(out_valid), 32'd0);
        check({tag, "_pcm"},   32'(out_pcm), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_prdy"},  32'(pcm_ready), 32'd1);
        check({tag, "_grdy"},  32'(gain_ready), 32'd1);
    endtask

    // Push one sample into an idle sequencer and follow it to the output handshake.
    task automatic one_sample(input logic [15:0] s, input logic [15:0] exp_out, input string tag);
        int cyc, nxt;
        out_ready = 1'b1;
        pcm_in    = s;
        pcm_valid = 1'b1;
        check({tag, "_rdy"}, 32'(pcm_ready), 32'd1);
        tick();
        pcm_valid = 1'b0;
        cyc = 0;
        nxt = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
            if (bq_next) begin
                nxt++;
                check({tag, "_q15"}, bq_data, exp_q15(s));
            end
        end
        check({tag, "_lat"}, cyc, 3 + SETTLE);
        check({tag, "_npulse"}, nxt, 32'd1);
        check({tag, "_pcm"}, 32'(out_pcm), 32'(exp_out));
        check({tag, "_qhold"}, bq_data, exp_q15(s));
        tick();
        check({tag, "_vclr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] s, a, b;
        logic [15:0] bp [4];
        logic [15:0] exp_q [$];
        logic [15:0] got [$];
        logic [15:0] first;
        int cyc, gap, extra_set, stable_bad, activity;
        bit have_first;

        repeat (3) tick();
        check_zero("rst");
        rst = 1'b0;
        tick();

        one_sample(16'h1000, 16'h1000, "pass");
        one_sample(16'hffff, 16'hffff, "neg1");
        one_sample(16'h8000, 16'h8000, "negmax");
        for (int i = 0; i < 6; i++) begin
            s = 16'($urandom);
            one_sample(s, s, "rnd");
        end

        bq_force = 1'b1;
        bq_force_val = 32'h7fff_ffff;
        one_sample(16'h0123, ref_pcm(bq_force_val), "satp");
        check("satp_ref", 32'(ref_pcm(32'h7fff_ffff)), 32'h7fff);
        bq_force_val = 32'h8000_0000;
        one_sample(16'h0456, 16'h8000, "satn");
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) bq_force_val = $urandom;
            else            bq_force_val = 32'($signed(24'($urandom)));
            one_sample(16'($urandom), ref_pcm(bq_force_val), "rsat");
        end
        bq_force = 1'b0;

        // Gain priority: B in flight and held in OUT while A and a gain queue up.
        b = 16'($urandom);
        a = 16'($urandom);
        out_ready = 1'b0;
        pcm_in = b;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        tick();
        pcm_in = a;
        pcm_valid = 1'b1;
        gain_in = 16'd6;
        gain_valid = 1'b1;
        check("gp_rdy_a", 32'(pcm_ready), 32'd1);
        check("gp_rdy_g", 32'(gain_ready), 32'd1);
        tick();
        pcm_valid = 1'b0;
        gain_valid = 1'b0;
        check("gp_pending", 32'(gain_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        check("gp_b_pcm", 32'(out_pcm), 32'(b));
        repeat (3) tick();
        check("gp_hold_noset", 32'(bq_set), 32'd0);
        check("gp_hold_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        cyc = 0;
        while (!bq_set && cyc < 10) begin tick(); cyc++; end
        check("gp_set_seen", 32'(bq_set), 32'd1);
        check("gp_set_gain", 32'(bq_gain), 32'h0006);
        check("gp_set_grdy", 32'(gain_ready), 32'd1);
        gap = 0;
        extra_set = 0;
        tick();
        while (!bq_next && gap < 30) begin
            if (bq_set) extra_set++;
            gap++;
            tick();
        end
        check("gp_gap", gap, SET_WAIT);
        check("gp_set_width", extra_set, 32'd0);
        check("gp_a_q15", bq_data, exp_q15(a));
        check("gp_gain_hold", 32'(bq_gain), 32'h0006);
        cyc = 0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        check("gp_a_pcm", 32'(out_pcm), 32'(a));
        tick();

        // Backpressure: downstream stalled, four samples offered back to back.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bp[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            pcm_in = bp[i];
            pcm_valid = 1'b1;
            if (pcm_ready) exp_q.push_back(bp[i]);
            tick();
        end
        check("bp_accepted", exp_q.size(), 32'd3);
        check("bp_full", 32'(pcm_ready), 32'd0);
        stable_bad = 0;
        have_first = 1'b0;
        first = '0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                if (!have_first) begin first = out_pcm; have_first = 1'b1; end
                else if (out_pcm !== first) stable_bad++;
            end
            if (pcm_ready) stable_bad++;
            tick();
        end
        check("bp_stable", stable_bad, 32'd0);
        check("bp_first", 32'(first), 32'(bp[0]));
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 4 && cyc < 200) begin
            if (pcm_valid && pcm_ready) exp_q.push_back(pcm_in);
            if (out_valid) got.push_back(out_pcm);
            tick();
            if (exp_q.size() == 4) pcm_valid = 1'b0;
            cyc++;
        end
        pcm_valid = 1'b0;
        check("bp_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check("bp_order", 32'(got[i]), (i < exp_q.size()) ? 32'(exp_q[i]) : 32'hdead);

        // Reset during SETTLE with a sample queued and a gain pending.
        pcm_in = 16'h2222;
        pcm_valid = 1'b1;
        tick();
        pcm_in = 16'h3333;
        gain_in = 16'd9;
        gain_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        gain_valid = 1'b0;
        tick();
        tick();
        check("mrst_pre_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1 check_zero("mrst");
        tick();
        rst = 1'b0;
        activity = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (busy || bq_set || bq_next || out_valid) activity++;
        end
        check("mrst_discard", activity, 32'd0);
        s = 16'($urandom);
        one_sample(s, s, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
